// File: rtl/picomips_sequencer_if.sv
// Bus between the picoMips sequencer and the program ROM / accumulator datapath.
// The master side is the sequencer; the slave side is the ROM plus ALU/register file.
interface picomips_sequencer_if #(
    parameter int PC_W = 5
);
    logic [7:0]      instr;
    logic [PC_W-1:0] pc;
    logic            acc_we;
    logic            reg_we;
    logic            reg_addr;

    modport master (
        input  instr,
        output pc,
        output acc_we,
        output reg_we,
        output reg_addr
    );

    modport slave (
        output instr,
        input  pc,
        input  acc_we,
        input  reg_we,
        input  reg_addr
    );
endinterface

// File: rtl/picomips_sequencer.sv
// picoMips control unit: 4-phase instruction FSM, program counter, write strobes
// and the SW8 wait-for-edge (HEI) handshake on a synchronised, debounced switch.
module picomips_sequencer #(
    parameter int PC_W     = 5,
    parameter int PROG_LEN = 24,
    parameter int DEB_CYC  = 16
) (
    input  logic                   Clock,
    input  logic                   nReset,
    input  logic                   go_sw,
    input  logic                   halt_req,
    picomips_sequencer_if.master   bus,
    output logic                   waiting,
    output logic                   halted,
    output logic                   wrap
);
    localparam logic [2:0] OP_ATR = 3'b110;
    localparam logic [2:0] OP_HEI = 3'b111;
    localparam int         CNT_W  = $clog2(DEB_CYC + 1);

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_WB,
        S_HOLD,
        S_PARK
    } state_t;

    state_t          state_reg;
    logic [PC_W-1:0] pc_reg;
    logic [2:0]      func_reg;
    logic            arg0_reg;
    logic            acc_we_reg;
    logic            reg_we_reg;
    logic            waiting_reg;
    logic            halted_reg;
    logic            wrap_reg;

    logic [1:0]       go_sync_reg;
    logic             go_db_reg;
    logic [CNT_W-1:0] deb_cnt_reg;

    logic            is_hei;
    logic            is_atr;
    logic            pc_last;
    logic            unused_arg_bits;

    // Only arg[0] matters to the sequencer; the rest of the operand belongs to the datapath.
    assign unused_arg_bits = ^bus.instr[4:1];

    assign is_hei  = (func_reg == OP_HEI);
    assign is_atr  = (func_reg == OP_ATR);
    assign pc_last = (pc_reg == PC_W'(PROG_LEN - 1));

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            go_sync_reg <= 2'b00;
        end else begin
            go_sync_reg <= {go_sync_reg[0], go_sw};
        end
    end

    // A new SW8 level is accepted only after DEB_CYC consecutive differing samples.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            go_db_reg   <= 1'b0;
            deb_cnt_reg <= '0;
        end else if (go_sync_reg[1] == go_db_reg) begin
            deb_cnt_reg <= '0;
        end else if (deb_cnt_reg == CNT_W'(DEB_CYC - 1)) begin
            go_db_reg   <= go_sync_reg[1];
            deb_cnt_reg <= '0;
        end else begin
            deb_cnt_reg <= deb_cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state_reg   <= S_FETCH;
            pc_reg      <= '0;
            func_reg    <= 3'b000;
            arg0_reg    <= 1'b0;
            acc_we_reg  <= 1'b0;
            reg_we_reg  <= 1'b0;
            waiting_reg <= 1'b0;
            halted_reg  <= 1'b0;
            wrap_reg    <= 1'b0;
        end else begin
            acc_we_reg <= 1'b0;
            reg_we_reg <= 1'b0;
            wrap_reg   <= 1'b0;
            case (state_reg)
                S_FETCH: begin
                    state_reg <= S_DECODE;
                end
                S_DECODE: begin
                    func_reg  <= bus.instr[7:5];
                    arg0_reg  <= bus.instr[0];
                    state_reg <= S_EXEC;
                end
                S_EXEC: begin
                    if (is_hei && (go_db_reg == arg0_reg)) begin
                        state_reg   <= S_HOLD;
                        waiting_reg <= 1'b1;
                    end else begin
                        state_reg  <= S_WB;
                        acc_we_reg <= !(is_hei || is_atr);
                        reg_we_reg <= is_atr;
                    end
                end
                S_HOLD: begin
                    // Only HEI reaches HOLD, so neither strobe fires on the way out.
                    if (go_db_reg != arg0_reg) begin
                        state_reg   <= S_WB;
                        waiting_reg <= 1'b0;
                    end
                end
                S_WB: begin
                    pc_reg   <= pc_last ? '0 : pc_reg + 1'b1;
                    wrap_reg <= pc_last;
                    if (halt_req) begin
                        state_reg  <= S_PARK;
                        halted_reg <= 1'b1;
                    end else begin
                        state_reg <= S_FETCH;
                    end
                end
                S_PARK: begin
                    if (!halt_req) begin
                        state_reg  <= S_FETCH;
                        halted_reg <= 1'b0;
                    end
                end
                default: begin
                    state_reg   <= S_FETCH;
                    waiting_reg <= 1'b0;
                    halted_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.pc       = pc_reg;
    assign bus.acc_we   = acc_we_reg;
    assign bus.reg_we   = reg_we_reg;
    assign bus.reg_addr = arg0_reg;
    assign waiting      = waiting_reg;
    assign halted       = halted_reg;
    assign wrap         = wrap_reg;
endmodule

// File: tb/tb_picomips_sequencer.sv
// Directed bench for picomips_sequencer: a sync ROM model feeds the DUT and a
// retire monitor pops per-instruction expectations from a scoreboard queue.
module tb_picomips_sequencer;
    localparam int PC_W     = 5;
    localparam int PROG_LEN = 24;
    localparam int DEB_CYC  = 16;
    localparam logic [2:0] OP_ATR = 3'b110;
    localparam logic [2:0] OP_HEI = 3'b111;

    typedef struct {
        int pc;
        int acc;
        int regw;
        int ra;
        int wrp;
        int cyc;
        int waits;
    } exp_t;

    logic Clock = 1'b0;
    logic nReset;
    logic go_sw;
    logic halt_req;
    logic waiting;
    logic halted;
    logic wrap;

    logic [7:0] rom [0:31];
    exp_t       exp_q[$];
    int         checks   = 0;
    int         failures = 0;

    int              cyc_n, acc_n, reg_n, wr_n, wait_n, both_n;
    logic            ra_s;
    logic [PC_W-1:0] prev_pc;

    picomips_sequencer_if #(.PC_W(PC_W)) bus ();

    picomips_sequencer #(
        .PC_W    (PC_W),
        .PROG_LEN(PROG_LEN),
        .DEB_CYC (DEB_CYC)
    ) dut (
        .Clock   (Clock),
        .nReset  (nReset),
        .go_sw   (go_sw),
        .halt_req(halt_req),
        .bus     (bus),
        .waiting (waiting),
        .halted  (halted),
        .wrap    (wrap)
    );

    always #5 Clock = ~Clock;

    // Synchronous ROM with one cycle of read latency.
    always @(posedge Clock) bus.instr <= rom[bus.pc];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // A change of pc marks an instruction retiring; compare what was seen since the last one.
    always @(negedge Clock) begin
        exp_t e;
        if (!nReset) begin
            cyc_n = 0; acc_n = 0; reg_n = 0; wr_n = 0; wait_n = 0; both_n = 0;
            ra_s = 1'b0;
            prev_pc = bus.pc;
        end else begin
            cyc_n++;
            acc_n  += int'(bus.acc_we);
            reg_n  += int'(bus.reg_we);
            wr_n   += int'(wrap);
            wait_n += int'(waiting);
            both_n += int'(bus.acc_we && bus.reg_we);
            if (bus.reg_we) ra_s = bus.reg_addr;
            if (bus.pc !== prev_pc) begin
                check("retire_expected", (exp_q.size() != 0), 1'b1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    $display("retire pc %0d->%0d cyc=%0d acc=%0d reg=%0d wrap=%0d wait=%0d",
                             prev_pc, bus.pc, cyc_n, acc_n, reg_n, wr_n, wait_n);
                    check("retire_pc", bus.pc, e.pc);
                    check("acc_we_count", acc_n, e.acc);
                    check("reg_we_count", reg_n, e.regw);
                    check("wrap_count", wr_n, e.wrp);
                    check("strobe_exclusive", both_n, 0);
                    if (e.ra != -1)    check("reg_addr", ra_s, e.ra);
                    if (e.cyc != -1)   check("instr_cycles", cyc_n, e.cyc);
                    if (e.waits != -1) check("waiting_cycles", wait_n, e.waits);
                end
                cyc_n = 0; acc_n = 0; reg_n = 0; wr_n = 0; wait_n = 0; both_n = 0;
                prev_pc = bus.pc;
            end
        end
    end

    task automatic push(input int pc, input int acc, input int regw, input int ra,
                        input int wrp, input int cyc, input int waits);
        exp_t e;
        e.pc = pc; e.acc = acc; e.regw = regw; e.ra = ra;
        e.wrp = wrp; e.cyc = cyc; e.waits = waits;
        exp_q.push_back(e);
    endtask

    task automatic wait_pc(input int value, input int bound);
        int n = 0;
        while (bus.pc !== PC_W'(value) && n < bound) begin
            @(negedge Clock);
            n++;
        end
        check("wait_pc", bus.pc, value);
    endtask

    task automatic wait_waiting(input logic value, input int bound);
        int n = 0;
        while (waiting !== value && n < bound) begin
            @(negedge Clock);
            n++;
        end
        check("wait_waiting", waiting, value);
    endtask

    task automatic wait_drain(input int bound);
        int n = 0;
        while (exp_q.size() != 0 && n < bound) begin
            @(negedge Clock);
            n++;
        end
        check("scoreboard_drain", exp_q.size(), 0);
    endtask

    task automatic check_reset_outputs(input string phase);
        check({phase, "_pc"}, bus.pc, 0);
        check({phase, "_acc_we"}, bus.acc_we, 0);
        check({phase, "_reg_we"}, bus.reg_we, 0);
        check({phase, "_reg_addr"}, bus.reg_addr, 0);
        check({phase, "_waiting"}, waiting, 0);
        check({phase, "_halted"}, halted, 0);
        check({phase, "_wrap"}, wrap, 0);
    endtask

    initial begin
        int n;
        logic [2:0] f;
        nReset   = 1'b0;
        go_sw    = 1'b0;
        halt_req = 1'b0;

        // Program A: 24 ALU-type ops, including unassigned Func codes.
        for (int i = 0; i < 32; i++) begin
            f = 3'(i % 6);
            rom[i] = {f, 5'(i)};
        end
        @(negedge Clock);
        @(negedge Clock);
        check_reset_outputs("reset");
        for (int i = 0; i < PROG_LEN; i++)
            push((i + 1) % PROG_LEN, 1, 0, -1, (i == PROG_LEN - 1) ? 1 : 0, 4, 0);
        #2 nReset = 1'b1;
        wait_drain(PROG_LEN * 4 + 20);

        // Program B: HEI, ATR and halt scenarios.
        @(negedge Clock);
        #2 nReset = 1'b0;
        @(negedge Clock);
        @(negedge Clock);
        for (int i = 0; i < 32; i++) rom[i] = {3'b001, 5'd3};
        rom[1] = {OP_HEI, 5'd0};
        rom[2] = {OP_HEI, 5'd0};
        rom[3] = {OP_HEI, 5'd1};
        rom[4] = {OP_ATR, 5'd1};
        rom[5] = {OP_ATR, 5'd0};
        rom[6] = {3'b010, 5'd9};
        rom[7] = {OP_HEI, 5'd0};
        push(1, 1, 0, -1, 0, 4, 0);
        push(2, 0, 0, -1, 0, -1, -1);
        push(3, 0, 0, -1, 0, 4, 0);
        push(4, 0, 0, -1, 0, -1, -1);
        push(5, 0, 1, 1, 0, -1, 0);
        push(6, 0, 1, 0, 0, 4, 0);
        push(7, 1, 0, -1, 0, 4, 0);
        #2 nReset = 1'b1;

        wait_waiting(1'b1, 30);
        check("hei0_pc_frozen", bus.pc, 1);
        go_sw = 1'b1;
        repeat (10) @(negedge Clock);
        go_sw = 1'b0;
        repeat (30) @(negedge Clock);
        check("glitch_still_waiting", waiting, 1);
        check("glitch_pc_frozen", bus.pc, 1);

        go_sw = 1'b1;
        n = 0;
        while (waiting === 1'b1 && n < 40) begin
            @(negedge Clock);
            n++;
        end
        $display("hei release latency %0d cycles", n);
        check("hei_release_latency_ok", (n >= 2 + DEB_CYC && n <= 3 + DEB_CYC), 1'b1);

        wait_pc(3, 40);
        wait_waiting(1'b1, 30);
        halt_req = 1'b1;
        repeat (3) @(negedge Clock);
        check("halt_in_hold_waiting", waiting, 1);
        check("halt_in_hold_not_halted", halted, 0);
        go_sw = 1'b0;
        wait_pc(4, 60);
        check("halt_after_hei_halted", halted, 1);
        repeat (5) @(negedge Clock);
        check("halt_after_hei_pc", bus.pc, 4);
        halt_req = 1'b0;
        @(negedge Clock);
        check("unpark_after_hei", halted, 0);

        wait_pc(6, 40);
        @(negedge Clock);
        @(negedge Clock);
        halt_req = 1'b1;
        wait_pc(7, 20);
        check("halt_exec_halted", halted, 1);
        n = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge Clock);
            if (bus.pc === PC_W'(7) && halted === 1'b1) n++;
        end
        check("park_stable_cycles", n, 50);
        halt_req = 1'b0;
        @(negedge Clock);
        check("unpark_halted", halted, 0);
        check("unpark_pc", bus.pc, 7);

        // Asynchronous reset while blocked in HOLD at pc=7.
        wait_waiting(1'b1, 20);
        check("hold_pc7", bus.pc, 7);
        #2 nReset = 1'b0;
        #1 check_reset_outputs("async_reset");
        @(negedge Clock);
        check("reset_held_pc", bus.pc, 0);
        push(1, 1, 0, -1, 0, 4, 0);
        #2 nReset = 1'b1;
        wait_drain(20);
        check("final_queue_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/picomips_sequencer.md
Name: picomips_sequencer

Overview:
- Control unit for the picoMips accumulator datapath.
- Replaces the free-running program counter and ad-hoc decode with an explicit 4-phase instruction FSM.
- Generates the program-memory address, accumulator and register write strobes, and the SW8 "wait-for-edge" (HEI) handshake, using a synchronised and debounced copy of the raw switch.
- Sits between the program ROM (synchronous, 1-cycle read) and the ALU/register file.

Parameters:
- PC_W, 5, instruction address width.
- PROG_LEN, 24, number of valid instructions; PC wraps from PROG_LEN-1 to 0.
- DEB_CYC, 16, consecutive stable samples required to accept a new SW8 level (must be ≥2).

Ports:
- Clock  input  1  system clock, rising edge.
- nReset  input  1  asynchronous, active-low reset.
- instr  input  8  instruction word from the sync ROM; Func=instr[7:5], arg=instr[4:0].
- go_sw  input  1  raw SW[8], asynchronous to Clock.
- halt_req  input  1  level; when high, stop at the next instruction boundary.
- pc  output  PC_W  program-memory address.
- acc_we  output  1  accumulator write strobe.
- reg_we  output  1  register-file write strobe.
- reg_addr  output  1  register select, equal to instr[0].
- waiting  output  1  high while blocked on HEI.
- halted  output  1  high while parked by halt_req.
- wrap  output  1  one-cycle pulse when pc wraps to 0.

Behaviour:
- Reset (asynchronous, nReset=0):
  - pc=0, state=FETCH, go_db=0, debounce count=0.
  - acc_we, reg_we, waiting, halted and wrap are all 0.
  - Deasserting nReset mid-instruction or mid-HOLD resumes at FETCH with pc=0.
- Input conditioning:
  - go_sw passes through a 2-flop synchroniser.
  - go_db changes only after the synchronised value differs from go_db for DEB_CYC consecutive cycles.
  - Any sample equal to go_db clears the count.
- FSM states: FETCH, DECODE, EXEC, WB, HOLD, PARK.
  - FETCH→DECODE: ROM latency; instr is valid from DECODE onward.
  - DECODE→EXEC unconditionally.
  - EXEC→HOLD if Func==OP_HEI and go_db==instr[0]; otherwise EXEC→WB.
  - HOLD→WB on the first cycle in which go_db!=instr[0].
    - HEI arg 0 = wait for SW8 to become 1; arg 1 = wait for SW8 to become 0.
    - A level already satisfied in EXEC skips HOLD.
  - WB→PARK if halt_req=1; otherwise WB→FETCH.
  - PARK→FETCH when halt_req=0.
- PC: increments at the WB exit (→FETCH or →PARK). If pc==PROG_LEN-1 it loads 0 and wrap pulses for that one cycle. pc is stable in every other state.
- Strobes (Moore decode of the state flops, glitch-free):
  - acc_we=1 for exactly one cycle in WB, unless Func is OP_HEI or OP_ATR.
  - reg_we=1 for exactly one cycle in WB, only when Func==OP_ATR.
  - acc_we and reg_we are never high together.
- Status outputs: waiting=1 iff state==HOLD; halted=1 iff state==PARK.
- Opcodes: OP_HEI and OP_ATR come from the shared opcode definitions. Unknown Func values are treated as ALU ops (acc_we in WB).
- Throughput: 4 cycles per non-blocking instruction; HEI costs 4 cycles plus the HOLD time.
- Simultaneous events:
  - halt_req rising during HOLD takes effect only after the HEI completes (PARK at the following WB exit).
  - A go_db change in the same cycle as entering EXEC is evaluated on the new value.

Test Plan:
- Reset then ROM of 24 ALU ops, go_sw=0, halt_req=0:
  - pc steps 0,1,2… every 4 cycles.
  - acc_we pulses once per instruction, in WB.
  - wrap pulses when pc goes 23→0 at cycle 96.
- instr=HEI arg0, go_sw=0:
  - waiting=1, pc frozen.
  - Raise go_sw: waiting falls after 2+DEB_CYC(=16) cycles, then WB, pc+1, acc_we=0.
- instr=HEI arg0 with go_sw already 1 and debounced: HOLD skipped, 4-cycle instruction, waiting never asserted.
- Glitch: toggle go_sw for 10 cycles, then back, while in HOLD → go_db unchanged, still waiting.
- instr=ATR arg1 → reg_we=1 for one cycle in WB, reg_addr=1, acc_we=0.
- halt_req=1 mid-EXEC → pc increments once, halted=1, pc stable for 50 cycles. Drop halt_req → FETCH next cycle.
- nReset pulsed low while in HOLD at pc=7 → all outputs 0, pc=0 immediately (asynchronous). FETCH resumes after release.
